// File: rtl/utils_pkg.sv
// Shared core-bus types. s_rd_rsp_t is the payload carried by the read
// responder's delay pipeline and response queue.
package utils_pkg;

  typedef logic [31:0] cb_addr_t;

  typedef enum logic [1:0] {
    CB_BYTE = 2'd0,
    CB_HALF = 2'd1,
    CB_WORD = 2'd2
  } cb_size_t;

  typedef enum logic [1:0] {
    CB_OKAY   = 2'd0,
    CB_EXOKAY = 2'd1,
    CB_SLVERR = 2'd2,
    CB_DECERR = 2'd3
  } cb_resp_t;

  typedef struct packed {
    logic        wr_addr_valid;
    cb_addr_t    wr_addr;
    cb_size_t    wr_size;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic [3:0]  wr_strobe;
    logic        wr_resp_ready;
    logic        rd_addr_valid;
    cb_addr_t    rd_addr;
    cb_size_t    rd_size;
    logic        rd_ready;
  } s_cb_mosi_t;

  typedef struct packed {
    logic        wr_addr_ready;
    logic        wr_ready;
    logic        wr_resp_valid;
    cb_resp_t    wr_resp;
    logic        rd_addr_ready;
    logic        rd_valid;
    logic [31:0] rd_data;
    cb_resp_t    rd_resp;
  } s_cb_miso_t;

  typedef struct packed {
    cb_resp_t    resp;
    logic [31:0] data;
  } s_rd_rsp_t;

endpackage

// File: rtl/fifo.sv
// Generic synchronous FIFO with any slot count (not only powers of two).
// Writes when full and reads when empty are ignored.
module fifo #(
  parameter int SLOTS = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             write_i,
  input  logic             read_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int CNT_W = $clog2(SLOTS + 1);

  logic [WIDTH-1:0] mem_q [SLOTS];
  logic [WIDTH-1:0] mem_d [SLOTS];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_wr, do_rd;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(SLOTS - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign full_o  = (cnt_q == CNT_W'(SLOTS));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign do_wr   = write_i && !full_o;
  assign do_rd   = read_i && !empty_o;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_wr) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_rd) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (do_wr && !do_rd) cnt_d = cnt_q + CNT_W'(1);
    else if (!do_wr && do_rd) cnt_d = cnt_q - CNT_W'(1);
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  // State registers; everything clears on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SLOTS; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      for (int i = 0; i < SLOTS; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/cb_rd_responder.sv
// Core-bus read responder in front of a synchronous word memory.
// Requests are decoded and issued to the memory in the acceptance cycle,
// delayed WAIT_ST cycles in a non-stalling pipeline, then queued in a
// response FIFO. A credit counter (pipeline + FIFO occupancy) bounds
// in-flight reads to MAX_OT_TXN so the pipeline never needs to stall.
//
// Handshake: a request transfers on any rising edge where rd_addr_valid and
// rd_addr_ready are both high; a response transfers on any rising edge where
// rd_valid and rd_ready are both high. While rd_valid is high and rd_ready is
// low, rd_valid/rd_data/rd_resp hold their values.
module cb_rd_responder
  import utils_pkg::*;
#(
  parameter cb_addr_t BASE_ADDR  = 32'h0000_0000,
  parameter int       SIZE_BYTES = 4096,
  parameter int       MAX_OT_TXN = 4,
  parameter int       WAIT_ST    = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  s_cb_mosi_t                      instr_cb_mosi_i,
  output s_cb_miso_t                      instr_cb_miso_o,
  output logic                            mem_rd_o,
  output logic [$clog2(SIZE_BYTES/4)-1:0] mem_addr_o,
  input  logic [31:0]                     mem_data_i
);

  localparam int IDX_W = $clog2(SIZE_BYTES / 4);
  localparam int CNT_W = $clog2(MAX_OT_TXN) + 1;
  localparam int MAX_W = 7;

  if ((SIZE_BYTES < 4) || ((SIZE_BYTES & (SIZE_BYTES - 1)) != 0) ||
      (MAX_OT_TXN < 1) || (WAIT_ST < 0) || (WAIT_ST > MAX_W)) begin : g_bad_param
    $error("cb_rd_responder: illegal parameters");
  end

  logic             alive_q, alive_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic             s0_vld_q, s0_vld_d;
  logic             s0_ok_q, s0_ok_d;
  logic             dly_vld_q [1:MAX_W];
  logic             dly_vld_d [1:MAX_W];
  s_rd_rsp_t        dly_rsp_q [1:MAX_W];
  s_rd_rsp_t        dly_rsp_d [1:MAX_W];
  logic             tap_vld   [0:MAX_W];
  s_rd_rsp_t        tap_rsp   [0:MAX_W];

  logic             addr_ready, accept, legal, pop;
  logic [32:0]      addr_ext, lo_ext, hi_ext;
  logic [IDX_W-1:0] word_idx;
  logic             fifo_full, fifo_empty;
  s_rd_rsp_t        fifo_dout;
  logic             unused_bits;

  // Request decode: 33-bit window compare so BASE_ADDR+SIZE_BYTES cannot wrap.
  always_comb begin
    addr_ext   = {1'b0, instr_cb_mosi_i.rd_addr};
    lo_ext     = {1'b0, BASE_ADDR};
    hi_ext     = lo_ext + 33'(SIZE_BYTES);
    word_idx   = IDX_W'((instr_cb_mosi_i.rd_addr - BASE_ADDR) >> 2);
    addr_ready = alive_q && (inflight_q < CNT_W'(MAX_OT_TXN));
    accept     = instr_cb_mosi_i.rd_addr_valid && addr_ready;
    legal      = (addr_ext >= lo_ext) && (addr_ext < hi_ext) &&
                 (instr_cb_mosi_i.rd_addr[1:0] == 2'b00) &&
                 (instr_cb_mosi_i.rd_size == CB_WORD);
    mem_rd_o   = accept && legal;
    mem_addr_o = mem_rd_o ? word_idx : '0;
  end

  // Delay pipeline: stage 0 turns memory data into a response, later stages shift.
  always_comb begin
    s0_vld_d   = accept;
    s0_ok_d    = accept && legal;
    tap_vld[0] = s0_vld_q;
    tap_rsp[0] = '0;
    if (s0_vld_q) begin
      tap_rsp[0].resp = s0_ok_q ? CB_OKAY : CB_SLVERR;
      tap_rsp[0].data = s0_ok_q ? mem_data_i : 32'h0;
    end
    for (int k = 1; k <= MAX_W; k++) begin
      tap_vld[k]   = dly_vld_q[k];
      tap_rsp[k]   = dly_rsp_q[k];
      dly_vld_d[k] = (k <= WAIT_ST) ? tap_vld[k-1] : 1'b0;
      dly_rsp_d[k] = (k <= WAIT_ST) ? tap_rsp[k-1] : '0;
    end
  end

  fifo #(
    .SLOTS(MAX_OT_TXN),
    .WIDTH($bits(s_rd_rsp_t))
  ) u_fifo_rsp (
    .clk    (clk),
    .rst    (rst),
    .clear_i(1'b0),
    .write_i(tap_vld[WAIT_ST]),
    .read_i (pop),
    .data_i (tap_rsp[WAIT_ST]),
    .data_o (fifo_dout),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // Credit count: +1 on accept, -1 on pop, unchanged when both happen.
  always_comb begin
    alive_d    = 1'b1;
    pop        = !fifo_empty && instr_cb_mosi_i.rd_ready;
    inflight_d = inflight_q;
    if (accept && !pop) inflight_d = inflight_q + CNT_W'(1);
    else if (!accept && pop) inflight_d = inflight_q - CNT_W'(1);
  end

  // Response channel shows the FIFO head; unused fields stay zero.
  always_comb begin
    instr_cb_miso_o               = '0;
    instr_cb_miso_o.rd_addr_ready = addr_ready;
    instr_cb_miso_o.rd_valid      = !fifo_empty;
    instr_cb_miso_o.rd_data       = fifo_empty ? 32'h0 : fifo_dout.data;
    instr_cb_miso_o.rd_resp       = fifo_empty ? CB_OKAY : fifo_dout.resp;
  end

  // Write-side request fields and the full flag are not needed here.
  assign unused_bits = ^{instr_cb_mosi_i, fifo_full};

  // State registers; reset drops every in-flight read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alive_q    <= 1'b0;
      inflight_q <= '0;
      s0_vld_q   <= 1'b0;
      s0_ok_q    <= 1'b0;
      for (int k = 1; k <= MAX_W; k++) begin
        dly_vld_q[k] <= 1'b0;
        dly_rsp_q[k] <= '0;
      end
    end else begin
      alive_q    <= alive_d;
      inflight_q <= inflight_d;
      s0_vld_q   <= s0_vld_d;
      s0_ok_q    <= s0_ok_d;
      for (int k = 1; k <= MAX_W; k++) begin
        dly_vld_q[k] <= dly_vld_d[k];
        dly_rsp_q[k] <= dly_rsp_d[k];
      end
    end
  end

endmodule

// File: tb/tb_cb_rd_responder.sv
// Directed bench for cb_rd_responder: one default instance (WAIT_ST=0,
// MAX_OT_TXN=4) and one with WAIT_ST=3, both on a behavioural word memory.
module tb_cb_rd_responder;
  import utils_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  s_cb_mosi_t  mosi, mosi3;
  s_cb_miso_t  miso, miso3;
  logic        mem_rd, mem_rd3;
  logic [9:0]  mem_addr, mem_addr3;
  logic [31:0] mem_data = 32'h0;
  logic [31:0] mem_data3 = 32'h0;
  int          errors = 0;
  int          checks = 0;

  cb_rd_responder dut (
    .clk(clk), .rst(rst), .instr_cb_mosi_i(mosi), .instr_cb_miso_o(miso),
    .mem_rd_o(mem_rd), .mem_addr_o(mem_addr), .mem_data_i(mem_data)
  );

  cb_rd_responder #(.WAIT_ST(3)) dut_w3 (
    .clk(clk), .rst(rst), .instr_cb_mosi_i(mosi3), .instr_cb_miso_o(miso3),
    .mem_rd_o(mem_rd3), .mem_addr_o(mem_addr3), .mem_data_i(mem_data3)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  // Memory contents: word 2 is DEADBEEF, every other word is C0DE0000+index.
  function automatic logic [31:0] exp_word(input int idx);
    if (idx == 2) return 32'hDEAD_BEEF;
    return 32'hC0DE_0000 + 32'(idx);
  endfunction

  always @(posedge clk) begin
    if (mem_rd)  mem_data  <= exp_word(int'(mem_addr));
    if (mem_rd3) mem_data3 <= exp_word(int'(mem_addr3));
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [31:0] a, input cb_size_t s);
    mosi.rd_addr_valid = 1'b1;
    mosi.rd_addr       = a;
    mosi.rd_size       = s;
  endtask

  task automatic idle();
    mosi.rd_addr_valid = 1'b0;
    mosi.rd_addr       = 32'h0;
    mosi.rd_size       = CB_WORD;
  endtask

  task automatic test_reset();
    mosi = '0;
    mosi3 = '0;
    rst = 1'b0;
    req(32'h8, CB_WORD);
    tick();
    tick();
    checks++; if (miso !== '0) begin errors++; $display("FAIL reset_miso: got %h want 0", miso); end
    checks++; if (miso3 !== '0) begin errors++; $display("FAIL reset_miso_w3: got %h want 0", miso3); end
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd: got %b want 0", mem_rd); end
    checks++; if (mem_addr !== 10'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    idle();
    rst = 1'b1;
    tick();
    checks++; if (miso.rd_addr_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", miso.rd_addr_ready); end
    checks++; if (miso.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_release_valid: got %b want 0", miso.rd_valid); end
  endtask

  task automatic test_single();
    mosi.rd_ready = 1'b0;
    req(32'h8, CB_WORD);
    #1;
    checks++; if (mem_rd !== 1'b1) begin errors++; $display("FAIL single_mem_rd: got %b want 1", mem_rd); end
    checks++; if (mem_addr !== 10'd2) begin errors++; $display("FAIL single_mem_addr: got %h want 2", mem_addr); end
    tick();
    idle();
    #1;
    checks++; if (miso.rd_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b want 0", miso.rd_valid); end
    tick();
    checks++; if (miso.rd_valid !== 1'b1) begin errors++; $display("FAIL single_valid_t2: got %b want 1", miso.rd_valid); end
    checks++; if (miso.rd_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_data: got %h want deadbeef", miso.rd_data); end
    checks++; if (miso.rd_resp !== CB_OKAY) begin errors++; $display("FAIL single_resp: got %0d want %0d", miso.rd_resp, CB_OKAY); end
    tick();
    checks++; if (miso.rd_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_hold: got %h want deadbeef", miso.rd_data); end
    mosi.rd_ready = 1'b1;
    tick();
    checks++; if (miso.rd_valid !== 1'b0) begin errors++; $display("FAIL single_pop: got %b want 0", miso.rd_valid); end
  endtask

  task automatic test_stream();
    mosi.rd_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c < 8) req(32'(c * 4), CB_WORD); else idle();
      #1;
      if (c < 8) begin
        checks++; if (miso.rd_addr_ready !== 1'b1) begin errors++; $display("FAIL stream_ready c=%0d: got %b want 1", c, miso.rd_addr_ready); end
      end
      if (c >= 2) begin
        checks++; if (miso.rd_valid !== 1'b1) begin errors++; $display("FAIL stream_valid c=%0d: got %b want 1", c, miso.rd_valid); end
        checks++; if (miso.rd_data !== exp_word(c - 2)) begin errors++; $display("FAIL stream_data c=%0d: got %h want %h", c, miso.rd_data, exp_word(c - 2)); end
      end else begin
        checks++; if (miso.rd_valid !== 1'b0) begin errors++; $display("FAIL stream_idle c=%0d: got %b want 0", c, miso.rd_valid); end
      end
      tick();
    end
    checks++; if (miso.rd_valid !== 1'b0) begin errors++; $display("FAIL stream_drain: got %b want 0", miso.rd_valid); end
  endtask

  task automatic test_backpressure();
    int n_acc = 0;
    int got = 0;
    logic [31:0] exp_q[$];
    mosi.rd_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (n_acc < 6) req(32'h10 + 32'(n_acc * 4), CB_WORD); else idle();
      #1;
      if (miso.rd_addr_ready) n_acc++;
      if (c == 6) begin
        checks++; if (miso.rd_addr_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b want 0", miso.rd_addr_ready); end
        checks++; if (miso.rd_data !== exp_word(4)) begin errors++; $display("FAIL bp_head: got %h want %h", miso.rd_data, exp_word(4)); end
      end
      tick();
    end
    checks++; if (n_acc !== 4) begin errors++; $display("FAIL bp_accepted: got %0d want 4", n_acc); end
    checks++; if (miso.rd_valid !== 1'b1 || miso.rd_data !== exp_word(4)) begin errors++; $display("FAIL bp_head_stable: got %b/%h want 1/%h", miso.rd_valid, miso.rd_data, exp_word(4)); end
    for (int i = 4; i < 10; i++) exp_q.push_back(exp_word(i));
    mosi.rd_ready = 1'b1;
    for (int c = 0; c < 30 && got < 6; c++) begin
      if (n_acc < 6) req(32'h10 + 32'(n_acc * 4), CB_WORD); else idle();
      #1;
      if (miso.rd_valid) begin
        logic [31:0] w = exp_q.pop_front();
        got++;
        checks++; if (miso.rd_data !== w || miso.rd_resp !== CB_OKAY) begin errors++; $display("FAIL bp_order #%0d: got %h/%0d want %h/0", got, miso.rd_data, miso.rd_resp, w); end
      end
      if (miso.rd_addr_ready && mosi.rd_addr_valid) n_acc++;
      tick();
    end
    idle();
    checks++; if (got !== 6 || n_acc !== 6) begin errors++; $display("FAIL bp_complete: got %0d/%0d want 6/6", got, n_acc); end
  endtask

  task automatic test_errors();
    logic [31:0] addrs [6] = '{32'h4, 32'h1000, 32'hC, 32'h6, 32'h10, 32'h14};
    cb_size_t    sizes [6] = '{CB_WORD, CB_WORD, CB_WORD, CB_WORD, CB_BYTE, CB_WORD};
    logic        oks   [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    mosi.rd_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c < 6) req(addrs[c], sizes[c]); else idle();
      #1;
      if (c < 6) begin
        checks++; if (mem_rd !== oks[c]) begin errors++; $display("FAIL err_mem_rd c=%0d: got %b want %b", c, mem_rd, oks[c]); end
        if (oks[c]) begin
          checks++; if (mem_addr !== 10'(addrs[c] >> 2)) begin errors++; $display("FAIL err_mem_addr c=%0d: got %h want %h", c, mem_addr, addrs[c] >> 2); end
        end
      end
      if (c >= 2) begin
        checks++;
        if (miso.rd_valid !== 1'b1 ||
            miso.rd_resp !== (oks[c-2] ? CB_OKAY : CB_SLVERR) ||
            miso.rd_data !== (oks[c-2] ? exp_word(int'(addrs[c-2] >> 2)) : 32'h0)) begin
          errors++;
          $display("FAIL err_rsp c=%0d: got %b/%0d/%h want legal=%b", c, miso.rd_valid, miso.rd_resp, miso.rd_data, oks[c-2]);
        end
      end
      tick();
    end
  endtask

  task automatic test_latency();
    mosi3.rd_ready = 1'b0;
    mosi3.rd_addr_valid = 1'b1;
    mosi3.rd_addr = 32'h8;
    mosi3.rd_size = CB_WORD;
    #1;
    checks++; if (miso3.rd_addr_ready !== 1'b1 || mem_rd3 !== 1'b1 || mem_addr3 !== 10'd2) begin errors++; $display("FAIL lat_issue: got %b/%b/%h want 1/1/2", miso3.rd_addr_ready, mem_rd3, mem_addr3); end
    tick();
    mosi3.rd_addr_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      #1;
      checks++; if (miso3.rd_valid !== 1'b0) begin errors++; $display("FAIL lat_early t+%0d: got %b want 0", k, miso3.rd_valid); end
      tick();
    end
    checks++; if (miso3.rd_valid !== 1'b1 || miso3.rd_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lat_t5: got %b/%h want 1/deadbeef", miso3.rd_valid, miso3.rd_data); end
    mosi3.rd_ready = 1'b1;
    tick();
    checks++; if (miso3.rd_valid !== 1'b0) begin errors++; $display("FAIL lat_pop: got %b want 0", miso3.rd_valid); end
  endtask

  task automatic test_reset_midflight();
    mosi.rd_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      req(32'(c * 4), CB_WORD);
      tick();
    end
    idle();
    #1;
    checks++; if (miso.rd_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid: got %b want 1", miso.rd_valid); end
    rst = 1'b0;
    #1;
    checks++; if (miso.rd_valid !== 1'b0 || miso.rd_addr_ready !== 1'b0) begin errors++; $display("FAIL rst_async: got %b/%b want 0/0", miso.rd_valid, miso.rd_addr_ready); end
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks++; if (miso.rd_addr_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b want 1", miso.rd_addr_ready); end
    mosi.rd_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      checks++; if (miso.rd_valid !== 1'b0) begin errors++; $display("FAIL rst_stale c=%0d: got %b want 0", c, miso.rd_valid); end
      tick();
    end
    req(32'hC, CB_WORD);
    tick();
    idle();
    tick();
    checks++; if (miso.rd_valid !== 1'b1 || miso.rd_data !== exp_word(3) || miso.rd_resp !== CB_OKAY) begin errors++; $display("FAIL rst_new_read: got %b/%h/%0d want 1/%h/0", miso.rd_valid, miso.rd_data, miso.rd_resp, exp_word(3)); end
    tick();
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_errors();
    test_latency();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cb_rd_responder.md
CB_RD_RESPONDER -- requirements
Module: cb_rd_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the first byte address served.
REQ-002 SHALL have parameter SIZE_BYTES, default 4096, meaning the window size; it SHALL be a power of two and at least 4.
REQ-003 SHALL have parameter MAX_OT_TXN, default 4, meaning the maximum number of accepted but not yet delivered reads.
REQ-004 SHALL have parameter WAIT_ST, default 0, meaning extra latency cycles (0..7).
REQ-005 clk  input  1  core clock; one clock, all logic rising-edge.
REQ-006 rst  input  1  reset; asynchronous assert, active-low.
REQ-007 instr_cb_mosi_i  input  s_cb_mosi_t  core-bus request; fields used are rd_addr_valid, rd_addr, rd_size and rd_ready.
REQ-008 instr_cb_miso_o  output  s_cb_miso_t  core-bus response; fields driven are rd_addr_ready, rd_valid, rd_data and rd_resp; all other fields SHALL be 0.
REQ-009 mem_rd_o  output  1  read strobe to the synchronous word memory.
REQ-010 mem_addr_o  output  $clog2(SIZE_BYTES/4)  word index into the memory.
REQ-011 mem_data_i  input  32  memory read data, valid one cycle after mem_rd_o.

Function
REQ-012 Acceptance SHALL occur in cycle t when rd_addr_valid && rd_addr_ready.
REQ-013 rd_addr_ready SHALL be high iff the in-flight count is below MAX_OT_TXN.
- In-flight count = pipeline stage occupancy + response FIFO occupancy.
REQ-014 An accepted request SHALL be legal iff all of the following hold:
- BASE_ADDR <= rd_addr < BASE_ADDR+SIZE_BYTES, with the comparison done in 33-bit arithmetic so no wrap occurs;
- rd_addr[1:0]==0;
- rd_size==CB_WORD.
REQ-015 For a legal request, cycle t SHALL drive mem_rd_o=1 and mem_addr_o=(rd_addr-BASE_ADDR)>>2.
REQ-016 For an illegal request, mem_rd_o SHALL stay 0, and the response SHALL be rd_resp=CB_SLVERR with rd_data=0.
REQ-017 A legal response SHALL carry rd_resp=CB_OKAY and rd_data=mem_data_i captured at t+1.
REQ-018 Responses SHALL enter the response FIFO at the end of cycle t+1+WAIT_ST; rd_valid SHALL assert no earlier than t+2+WAIT_ST.
REQ-019 The delay pipeline SHALL be a shift register of valid/resp/data stages that never stalls; the credit rule in REQ-013 guarantees FIFO space.
REQ-020 rd_valid SHALL equal FIFO not-empty; rd_data and rd_resp SHALL show the FIFO head.
REQ-021 The FIFO head SHALL pop when rd_valid && rd_ready.
REQ-022 While rd_valid && !rd_ready, rd_valid, rd_data and rd_resp SHALL be held stable.
REQ-023 Responses SHALL be returned strictly in acceptance order, including OKAY/SLVERR mixes.
REQ-024 Simultaneous accept and pop in one cycle SHALL leave the in-flight count unchanged.
REQ-025 Accept SHALL be possible every cycle: back-to-back reads with rd_ready=1 SHALL sustain 1 response/cycle when MAX_OT_TXN >= 2+WAIT_ST.
REQ-026 When the in-flight count equals MAX_OT_TXN, rd_addr_ready SHALL be 0 and no request SHALL be accepted, regardless of rd_addr_valid.
REQ-027 The in-flight counter width SHALL be $clog2(MAX_OT_TXN)+1 bits; it SHALL never underflow or overflow.

Reset
REQ-028 While rst=0, all of the following SHALL be 0: rd_addr_ready, rd_valid, rd_data, rd_resp (=CB_OKAY), mem_rd_o, mem_addr_o, the pipeline stages, the FIFO and the counter.
REQ-029 Reset mid-operation SHALL discard all in-flight reads; no response for them SHALL appear after release.
REQ-030 rd_addr_ready SHALL rise in the first cycle after reset deassertion.

Structure
REQ-031 Existing utils_pkg types SHALL be used: s_cb_mosi_t, s_cb_miso_t, cb_size_t, cb_resp_t, cb_addr_t.
REQ-032 A struct s_rd_rsp_t {resp, data} SHALL be added to utils_pkg; no other new package items SHALL be added.
REQ-033 The response queue SHALL be the existing fifo sub-module (u_fifo_rsp), with SLOTS=MAX_OT_TXN, WIDTH=$bits(s_rd_rsp_t) and clear_i=0.
REQ-034 An elaboration-time assertion SHALL reject illegal parameters: SIZE_BYTES not a power of two, MAX_OT_TXN<1, or WAIT_ST>7.

Verification
REQ-035 Single read: BASE=0, mem[2]=32'hDEAD_BEEF, read 0x8 at t -> rd_valid at t+2, rd_data=DEADBEEF, rd_resp=CB_OKAY.
REQ-036 Streaming: 8 reads 0x0..0x1C, rd_ready=1, WAIT_ST=0 -> 8 ordered responses on consecutive cycles; rd_addr_ready never drops.
REQ-037 Backpressure: rd_ready=0, MAX_OT_TXN=4, 6 requests -> exactly 4 accepted, then rd_addr_ready=0 with the head stable; release rd_ready -> remaining 2 accepted, all 6 delivered in order.
REQ-038 Errors: reads of 0x1000 (out of range, SIZE 4096), 0x6 (misaligned) and rd_size=CB_BYTE -> CB_SLVERR with data 0 and mem_rd_o never high; interleaved legal reads still return OKAY in order.
REQ-039 Latency: WAIT_ST=3 -> a single read accepted at t gives rd_valid at t+5.
REQ-040 Reset: rst=0 with 3 reads in flight -> after release no stale rd_valid, rd_addr_ready=1 next cycle, and a new read completes correctly.
